// File: rtl/tps_pkg.sv
// Shared types and helpers for the test pattern source.
// Contents: pattern mode encoding, FSM state encoding and the Galois LFSR
// step function. lfsr_next works at a fixed 64-bit width. Callers zero-extend
// narrower patterns into it and truncate the result back to their own width.
package tps_pkg;

    // Pattern modes. The encoding matches the 2-bit mode input.
    typedef enum logic [1:0] {
        TPS_INC   = 2'd0,
        TPS_DEC   = 2'd1,
        TPS_LFSR  = 2'd2,
        TPS_CONST = 2'd3
    } tps_mode_e;

    // Burst controller states.
    typedef enum logic {
        TPS_IDLE = 1'b0,
        TPS_RUN  = 1'b1
    } tps_state_e;

    // Widest pattern register the generator supports.
    localparam int TPS_MAX_W = 64;

    // One Galois LFSR step: shift right, and fold the taps in when the bit
    // that was shifted out was a one. A zero-extended input keeps its upper
    // bits at zero, provided the taps are also confined to the live width.
    function automatic logic [TPS_MAX_W-1:0] lfsr_next(
        input logic [TPS_MAX_W-1:0] p,
        input logic [TPS_MAX_W-1:0] taps
    );
        logic [TPS_MAX_W-1:0] r;
        r = p >> 1;
        if (p[0]) begin
            r = r ^ taps;
        end
        return r;
    endfunction

endpackage

// File: rtl/tps_pattern_gen.sv
// Pattern register for the test pattern source.
// On load, this block captures the seed, mode and stride. On each advance,
// it steps the pattern in the captured mode. An LFSR seed of zero is forced
// to all-ones when loaded, because the all-zero state never leaves itself.
module tps_pattern_gen
    import tps_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter logic [31:0] LFSR_TAPS = 32'h8020_0003
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  tps_mode_e         mode,
    input  logic [DATA_W-1:0] step,
    input  logic              advance,
    output logic [DATA_W-1:0] value
);

    // Only the low DATA_W bits of the feedback mask take part.
    localparam logic [DATA_W-1:0] TAPS_W = DATA_W'(LFSR_TAPS);

    logic [DATA_W-1:0] pat_q;
    logic [DATA_W-1:0] pat_d;
    logic [DATA_W-1:0] step_q;
    tps_mode_e         mode_q;
    logic [DATA_W-1:0] seed_fix;

    // Replace an all-zero LFSR seed with the all-ones lock-up escape value.
    always_comb begin
        seed_fix = seed;
        if (mode == TPS_LFSR && seed == '0) begin
            seed_fix = '1;
        end
    end

    // Next pattern value. Load takes priority over advance, and the step
    // uses the mode and stride latched at load.
    always_comb begin
        pat_d = pat_q;
        if (load) begin
            pat_d = seed_fix;
        end else if (advance) begin
            case (mode_q)
                TPS_INC:   pat_d = pat_q + step_q;
                TPS_DEC:   pat_d = pat_q - step_q;
                TPS_LFSR:  pat_d = DATA_W'(lfsr_next(TPS_MAX_W'(pat_q), TPS_MAX_W'(TAPS_W)));
                TPS_CONST: pat_d = pat_q;
                default:   pat_d = pat_q;
            endcase
        end
    end

    // Pattern register, with the mode and stride captured at load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= '0;
            step_q <= '0;
            mode_q <= TPS_INC;
        end else begin
            pat_q <= pat_d;
            if (load) begin
                step_q <= step;
                mode_q <= mode;
            end
        end
    end

    assign value = pat_q;

endmodule

// File: rtl/test_pattern_source.sv
// test_pattern_source: burst test-pattern generator on a valid/ready stream.
//
// Optional feature macro: TPS_LOOP_EN.
//   When it is defined, the block gains a 'loop' input. While loop is high at
//   the final handshake, the burst restarts with no bubble and no done pulse.
//   The pattern keeps advancing across the restart and is not reseeded.
//
// Stream handshake: m_valid, m_data and m_last come straight from registers.
// A beat moves on any cycle where m_valid && m_ready. While m_valid is high
// and m_ready is low, the payload and m_last hold steady. m_valid never drops
// without a handshake, except on abort or reset.
module test_pattern_source
    import tps_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          LEN_W     = 16,
    parameter logic [31:0] LFSR_TAPS = 32'h8020_0003
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [DATA_W-1:0] step,
    input  logic [LEN_W-1:0]  len,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
`ifdef TPS_LOOP_EN
    input  logic              loop,
`endif
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    tps_state_e       state_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q;
    logic             valid_q;
    logic             last_q;
    logic             done_q;

    logic             hs;
    logic             load;
    logic             loop_en;
    logic [LEN_W-1:0] cnt_nxt;
    logic             last_nxt;
    logic             last_reload;

`ifdef TPS_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    // A beat transfers only while valid is presented.
    assign hs   = valid_q && m_ready;
    // A zero-length request is dropped before it can reach RUN.
    assign load = (state_q == TPS_IDLE) && start && (len != '0);

    // m_last for the following beat. It is computed from the incremented
    // count, so the registered flag lines up with the payload it marks.
    assign cnt_nxt     = cnt_q + LEN_W'(1);
    assign last_nxt    = (cnt_nxt == (len_q - LEN_W'(1)));
    // m_last for beat 0 after a loop restart: set only for one-beat bursts.
    assign last_reload = (len_q == LEN_W'(1));

    // Burst controller: state, beat counter, latched length and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TPS_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                TPS_IDLE: begin
                    if (load) begin
                        state_q <= TPS_RUN;
                        len_q   <= len;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        last_q  <= (len == LEN_W'(1));
                    end
                end
                TPS_RUN: begin
                    if (abort) begin
                        // Abort wins over a handshake in the same cycle.
                        // That beat has still been taken downstream.
                        state_q <= TPS_IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (hs) begin
                        if (last_q) begin
                            if (loop_en) begin
                                cnt_q  <= '0;
                                last_q <= last_reload;
                            end else begin
                                state_q <= TPS_IDLE;
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q  <= cnt_nxt;
                            last_q <= last_nxt;
                        end
                    end
                end
                default: begin
                    state_q <= TPS_IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    tps_pattern_gen #(
        .DATA_W    (DATA_W),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_pattern (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .seed    (seed),
        .mode    (tps_mode_e'(mode)),
        .step    (step),
        .advance (hs),
        .value   (m_data)
    );

    assign m_valid = valid_q;
    assign m_last  = last_q;
    assign busy    = (state_q == TPS_RUN);
    assign done    = done_q;

endmodule
